// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode -- instruction decode stage with ID/EX pipeline register
//
// Decodes the opcode of the instruction held in the IF/ID latch into the
// writeback/memory/execute control groups. It reads rs and rt from a 32 x 32
// register file and registers everything into the ID/EX latch. The register
// file is written from the MEM/WB stage.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-high reset (ID/EX latch + reg file)
//   if_id_instr  [31:0] instruction from IF/ID
//   if_id_npc    [31:0] incremented PC from IF/ID
//   mem_wb_reg_write    register-file write enable
//   mem_wb_write_reg [4:0]  register-file write address (r0 writes dropped)
//   mem_wb_write_data [31:0] register-file write data
//   id_ex_wb     [1:0]  {regwrite, memtoreg}
//   id_ex_m      [2:0]  {branch, memread, memwrite}
//   id_ex_ex     [3:0]  {regdst, aluop[1:0], alusrc}
//   id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_sign_ext [31:0]
//   id_ex_instr_2016, id_ex_instr_1511 [4:0]
//
// Configuration
//   DECODE_RF_BYPASS_EN  defined: a same-cycle write to the register being
//                        read is forwarded to the read port (write-before-read).
//                        undefined: the read returns the old contents.
// -----------------------------------------------------------------------------
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_id_npc,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_write_reg,
    input  logic [31:0] mem_wb_write_data,
    output logic [1:0]  id_ex_wb,
    output logic [2:0]  id_ex_m,
    output logic [3:0]  id_ex_ex,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_rdata1,
    output logic [31:0] id_ex_rdata2,
    output logic [31:0] id_ex_sign_ext,
    output logic [4:0]  id_ex_instr_2016,
    output logic [4:0]  id_ex_instr_1511
);

    // Control word layout: {wb[1:0], m[2:0], ex[3:0]}
    function automatic logic [8:0] decode_ctrl(input logic [5:0] opcode);
        case (opcode)
            6'h00:   return {2'b10, 3'b000, 4'b1100};  // R-type
            6'h23:   return {2'b11, 3'b010, 4'b0001};  // lw
            6'h2B:   return {2'b00, 3'b001, 4'b0001};  // sw
            6'h04:   return {2'b00, 3'b100, 4'b0010};  // beq
            default: return 9'd0;                      // bubble
        endcase
    endfunction

    function automatic logic signed [31:0] sign_extend(input logic signed [15:0] imm);
        return 32'(imm);
    endfunction

    logic [31:0] rf [32];
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wr_en;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [8:0]  ctrl;

    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];
    assign ctrl  = decode_ctrl(if_id_instr[31:26]);
    assign wr_en = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

    // Register 0 is hardwired to zero on the read side as well, so its
    // storage never matters.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs != 5'd0) begin
            rdata1 = rf[rs];
`ifdef DECODE_RF_BYPASS_EN
            if (wr_en && (mem_wb_write_reg == rs)) rdata1 = mem_wb_write_data;
`endif
        end
        if (rt != 5'd0) begin
            rdata2 = rf[rt];
`ifdef DECODE_RF_BYPASS_EN
            if (wr_en && (mem_wb_write_reg == rt)) rdata2 = mem_wb_write_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[mem_wb_write_reg] <= mem_wb_write_data;
        end
    end

    // ID -> EX pipeline boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_wb         <= '0;
            id_ex_m          <= '0;
            id_ex_ex         <= '0;
            id_ex_npc        <= '0;
            id_ex_rdata1     <= '0;
            id_ex_rdata2     <= '0;
            id_ex_sign_ext   <= '0;
            id_ex_instr_2016 <= '0;
            id_ex_instr_1511 <= '0;
        end else begin
            id_ex_wb         <= ctrl[8:7];
            id_ex_m          <= ctrl[6:4];
            id_ex_ex         <= ctrl[3:0];
            id_ex_npc        <= if_id_npc;
            id_ex_rdata1     <= rdata1;
            id_ex_rdata2     <= rdata2;
            id_ex_sign_ext   <= sign_extend(if_id_instr[15:0]);
            id_ex_instr_2016 <= if_id_instr[20:16];
            id_ex_instr_1511 <= if_id_instr[15:11];
        end
    end

endmodule

// File: tb/tb_decode.sv
// -----------------------------------------------------------------------------
// tb_decode -- self-checking bench for decode
// Directed scenarios followed by random instructions/writes, checked against
// a reference model made of a register array and an opcode lookup table.
// -----------------------------------------------------------------------------
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg;
    logic [31:0] mem_wb_write_data;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rdata1;
    logic [31:0] id_ex_rdata2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_instr_2016;
    logic [4:0]  id_ex_instr_1511;

    decode dut (
        .clk(clk), .rst(rst),
        .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg(mem_wb_write_reg),
        .mem_wb_write_data(mem_wb_write_data),
        .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
        .id_ex_npc(id_ex_npc), .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
        .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr_2016(id_ex_instr_2016), .id_ex_instr_1511(id_ex_instr_1511)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state and expected ID/EX contents
    logic [31:0] m_rf [32];
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic [31:0] e_npc, e_r1, e_r2, e_se;
    logic [4:0]  e_2016, e_1511;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("wb",        32'(id_ex_wb),         32'(e_wb));
        chk("m",         32'(id_ex_m),          32'(e_m));
        chk("ex",        32'(id_ex_ex),         32'(e_ex));
        chk("npc",       id_ex_npc,             e_npc);
        chk("rdata1",    id_ex_rdata1,          e_r1);
        chk("rdata2",    id_ex_rdata2,          e_r2);
        chk("sign_ext",  id_ex_sign_ext,        e_se);
        chk("instr2016", 32'(id_ex_instr_2016), 32'(e_2016));
        chk("instr1511", 32'(id_ex_instr_1511), 32'(e_1511));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        e_wb = '0; e_m = '0; e_ex = '0; e_npc = '0; e_r1 = '0; e_r2 = '0;
        e_se = '0; e_2016 = '0; e_1511 = '0;
    endtask

    // Value the register file presents for a read this cycle
    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_RF_BYPASS_EN
        if (mem_wb_reg_write && mem_wb_write_reg == a) return mem_wb_write_data;
`endif
        return m_rf[a];
    endfunction

    // Compute expectations from current inputs, update model, clock, compare
    task automatic cycle();
        case (if_id_instr[31:26])
            6'h00:   begin e_wb = 2'b10; e_m = 3'b000; e_ex = 4'b1100; end
            6'h23:   begin e_wb = 2'b11; e_m = 3'b010; e_ex = 4'b0001; end
            6'h2B:   begin e_wb = 2'b00; e_m = 3'b001; e_ex = 4'b0001; end
            6'h04:   begin e_wb = 2'b00; e_m = 3'b100; e_ex = 4'b0010; end
            default: begin e_wb = 2'b00; e_m = 3'b000; e_ex = 4'b0000; end
        endcase
        e_npc  = if_id_npc;
        e_r1   = model_read(if_id_instr[25:21]);
        e_r2   = model_read(if_id_instr[20:16]);
        e_se   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        e_2016 = if_id_instr[20:16];
        e_1511 = if_id_instr[15:11];
        if (mem_wb_reg_write && mem_wb_write_reg != 5'd0)
            m_rf[mem_wb_write_reg] = mem_wb_write_data;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_id_instr       = instr;
        if_id_npc         = npc;
        mem_wb_reg_write  = we;
        mem_wb_write_reg  = wa;
        mem_wb_write_data = wd;
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        logic [31:0] old_r9;

        // Reset state
        rst = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        model_clear();
        #3;
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;

        // Preload r8 and r9
        drive(32'h0000_0000, 32'h100, 1'b1, 5'd8, 32'hDEAD_BEEF);
        cycle();
        drive(32'h0000_0000, 32'h104, 1'b1, 5'd9, 32'h0000_0011);
        cycle();

        // add r10,r8,r9
        drive(32'h0109_5020, 32'h108, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("add_rdata1", id_ex_rdata1, 32'hDEAD_BEEF);
        chk("add_rdata2", id_ex_rdata2, 32'h0000_0011);
        chk("add_wb", 32'(id_ex_wb), 32'(2'b10));
        chk("add_ex", 32'(id_ex_ex), 32'(4'b1100));
        chk("add_rd", 32'(id_ex_instr_1511), 32'd10);

        // lw r9,-4(r8)
        drive(32'h8D09_FFFC, 32'h10C, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("lw_se", id_ex_sign_ext, 32'hFFFF_FFFC);
        chk("lw_wb", 32'(id_ex_wb), 32'(2'b11));
        chk("lw_m", 32'(id_ex_m), 32'(3'b010));
        chk("lw_ex", 32'(id_ex_ex), 32'(4'b0001));
        chk("lw_rt", 32'(id_ex_instr_2016), 32'd9);
        chk("lw_npc", id_ex_npc, 32'h10C);

        // Write to r0 is discarded
        drive(32'h0000_0000, 32'h110, 1'b1, 5'd0, 32'h1234_5678);
        cycle();
        drive(32'h0000_0000, 32'h114, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("r0_read", id_ex_rdata1, 32'h0);

        // Same-cycle write/read of r9 via rt
        old_r9 = 32'h0000_0011;
        drive(32'h0009_5020, 32'h118, 1'b1, 5'd9, 32'h0000_0055);
        cycle();
`ifdef DECODE_RF_BYPASS_EN
        chk("bypass_rt", id_ex_rdata2, 32'h0000_0055);
`else
        chk("nobypass_rt", id_ex_rdata2, old_r9);
`endif
        drive(32'h0009_5020, 32'h11C, 1'b0, 5'd9, 32'hFFFF_FFFF);
        cycle();
        chk("after_write_rt", id_ex_rdata2, 32'h0000_0055);

        // Unlisted opcode and beq
        drive(32'hFC00_0000, 32'h120, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("bubble_ctrl", {23'd0, id_ex_wb, id_ex_m, id_ex_ex}, 32'd0);
        drive(32'h1109_000A, 32'h124, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("beq_m", 32'(id_ex_m), 32'(3'b100));
        chk("beq_ex", 32'(id_ex_ex), 32'(4'b0010));
        chk("beq_se", id_ex_sign_ext, 32'h0000_000A);

        // Random traffic with frequent read/write address collisions
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom_range(0, 63));
            endcase
            if_id_instr       = {op, r[25:0]};
            if_id_npc         = $urandom();
            mem_wb_reg_write  = 1'($urandom_range(0, 1));
            mem_wb_write_data = $urandom();
            case ($urandom_range(0, 3))
                0:       mem_wb_write_reg = r[25:21];
                1:       mem_wb_write_reg = r[20:16];
                default: mem_wb_write_reg = 5'($urandom_range(0, 31));
            endcase
            cycle();
        end

        // Mid-operation reset with a write pending
        drive(32'h0000_0000, 32'h200, 1'b1, 5'd5, 32'hA5A5_5A5A);
        cycle();
        drive(32'h1234_5678, 32'h204, 1'b1, 5'd7, 32'h7777_7777);
        #2;
        rst = 1'b1;
        model_clear();
        #2;
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;
        drive(32'h00A7_0000, 32'h208, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("rst_r5", id_ex_rdata1, 32'h0);
        chk("rst_r7", id_ex_rdata2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
